// File: rtl/codec_pkg.sv
// codec_pkg: shared constants, state type and cosine/alpha helpers for the IDCT path
// Widths: COEF_W coefficient, COS_W cosine/alpha (Q1.8), PIX_W pixel,
// TERM_W per-term product, ACC_W accumulator, FRAC fractional bits of a term.
package codec_pkg;
    localparam int BLOCK_SIZE = 8;
    localparam int COEF_W = 16;
    localparam int COS_W  = 9;
    localparam int PIX_W  = 9;
    localparam int TERM_W = 52;
    localparam int ACC_W  = 58;
    localparam int FRAC   = 32;

    typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} state_t;

    localparam logic signed [COS_W-1:0] ALPHA0 = 9'sh05B;
    localparam logic signed [COS_W-1:0] ALPHAK = 9'sh080;

    // round(256*cos(k*pi/16)) for k = 0..8; cos(0) = 256 sits one past the
    // signed Q1.8 range, so cosine values carry one extra integer bit
    localparam logic signed [COS_W:0] COS_MAG [9] = '{
        10'sd256, 10'sd251, 10'sd237, 10'sd213, 10'sd181,
        10'sd142, 10'sd98,  10'sd50,  10'sd0
    };

    function automatic logic signed [COS_W-1:0] alpha(input logic [2:0] k);
        return (k == 3'd0) ? ALPHA0 : ALPHAK;
    endfunction

    // C[x][u] = cos((2x+1)u*pi/16): the angle index is periodic in 32,
    // mirrored about 16 and negated past 8
    function automatic logic signed [COS_W:0] cos_q(input logic [2:0] x, input logic [2:0] u);
        logic [4:0] k;
        logic [4:0] m;
        k = 5'((2 * x + 1) * u);
        m = (k > 5'd16) ? 5'd0 - k : k;
        return (m > 5'd8) ? -COS_MAG[4'(5'd16 - m)] : COS_MAG[4'(m)];
    endfunction
endpackage

// File: rtl/idct_scan_counter.sv
// idct_scan_counter: 8x8 raster counter, y fastest, x on y wrap
// Ports: clk, rst_n (sync active-low), restart (force to (0,0)), go (advance),
//        x, y (current position), last (go at (7,7)).
module idct_scan_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       go,
    output logic [2:0] x,
    output logic [2:0] y,
    output logic       last
);
    always_ff @(posedge clk)
        if (!rst_n || restart)
            {x, y} <= '0;
        else if (go)
            {x, y} <= {x, y} + 6'd1;

    assign last = go && (x == 3'd7) && (y == 3'd7);
endmodule

// File: rtl/idct_2d.sv
// idct_2d: 8x8 inverse 2-D DCT, one pixel per cycle in raster order
// Ports: clk, rst_n (sync active-low), start_block (sampled in IDLE),
//        coef_in[u][v] (signed Q16.0), pixel_out[x][y] (signed Q9.0, registered),
//        busy (CALC/DONE), block_done (one-cycle pulse in DONE).
// Build option: define IDCT_SAT_EN to saturate pixels to [-256,255];
// otherwise the rounded result wraps to its low 9 bits.
module idct_2d
    import codec_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_block,
    input  logic signed [COEF_W-1:0] coef_in   [BLOCK_SIZE][BLOCK_SIZE],
    output logic signed [PIX_W-1:0]  pixel_out [BLOCK_SIZE][BLOCK_SIZE],
    output logic                     busy,
    output logic                     block_done
);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(64'sd1 << (FRAC - 1));
`ifdef IDCT_SAT_EN
    localparam logic signed [ACC_W-1:0] PMAX = ACC_W'(255);
    localparam logic signed [ACC_W-1:0] PMIN = ACC_W'(-256);
`endif

    state_t state, state_n;
    logic signed [COEF_W-1:0] coef_q [BLOCK_SIZE][BLOCK_SIZE];
    logic [2:0] x, y;
    logic last;
    logic signed [ACC_W-1:0] acc;
    logic signed [PIX_W-1:0] pix;
`ifdef IDCT_SAT_EN
    logic signed [ACC_W-1:0] sh;
`endif

    idct_scan_counter u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (state != CALC),
        .go      (state == CALC),
        .x       (x),
        .y       (y),
        .last    (last)
    );

    // DONE and the unused encoding both fall back to IDLE
    always_comb begin
        state_n = (state == IDLE) ? (start_block ? CALC : IDLE) :
                  (state == CALC) ? (last ? DONE : CALC) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            block_done <= 1'b0;
        end else begin
            state      <= state_n;
            busy       <= state_n != IDLE;
            block_done <= state_n == DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coef_q    <= '{default: '0};
            pixel_out <= '{default: '0};
        end else begin
            if (state == IDLE && start_block)
                coef_q <= coef_in;
            if (state == CALC)
                pixel_out[x][y] <= pix;
        end
    end

    always_comb begin
        acc = '0;
        for (int u = 0; u < BLOCK_SIZE; u++)
            for (int v = 0; v < BLOCK_SIZE; v++)
                acc = acc + ACC_W'(TERM_W'(alpha(3'(u))) * TERM_W'(alpha(3'(v))) *
                                   TERM_W'(cos_q(x, 3'(u))) * TERM_W'(cos_q(y, 3'(v))) *
                                   TERM_W'(coef_q[3'(u)][3'(v)]));
`ifdef IDCT_SAT_EN
        sh  = (acc + HALF) >>> FRAC;
        pix = (sh > PMAX) ? 9'sd255 : (sh < PMIN) ? 9'sh100 : PIX_W'(sh);
`else
        pix = PIX_W'((acc + HALF) >>> FRAC);
`endif
    end
endmodule
